// File: rtl/rmii_tx.sv
// RMII transmit framer: wraps a valid/ready/last byte stream into preamble, SFD,
// payload, zero pad and CRC-32 FCS, then holds the inter-packet gap.
module rmii_tx #(
    parameter int MIN_PAYLOAD    = 60,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IPG_DIBITS     = 48
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       phy_ce,
    input  logic       in_vld,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_rdy,
    output logic [1:0] eth_txd,
    output logic       eth_tx_en,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IPG} state_t;

    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES * 4 + 3);
    localparam logic [7:0]  IPG_LAST = 8'(IPG_DIBITS - 1);
    localparam logic [15:0] MIN_CNT  = 16'(MIN_PAYLOAD);
    localparam logic [7:0]  FCS_END  = 8'd16;

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [1:0]  didx_r;
    logic [7:0]  byte_r;
    logic        last_r;
    logic [15:0] count_r;
    logic [31:0] crc_r;
    logic [31:0] fcs_r;
    logic        fetch_s;
    logic [15:0] count_inc_s;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Fetch strobe: the phy_ce cycle that loads the last SFD dibit or the last dibit of a payload byte.
    always_comb begin
        fetch_s     = 1'b0;
        count_inc_s = (count_r == 16'hFFFF) ? count_r : (count_r + 16'd1);
        if (phy_ce && state_r == PREAMBLE && cnt_r == PRE_LAST) begin
            fetch_s = 1'b1;
        end else if (phy_ce && state_r == DATA && didx_r == 2'd3 && !last_r) begin
            fetch_s = 1'b1;
        end else begin
            fetch_s = 1'b0;
        end
    end

    // in_rdy has to be high in the very phy_ce cycle, so it is qualified combinationally.
    assign in_rdy = resetn & fetch_s;

    // Framing FSM with registered PHY outputs; everything advances on phy_ce only.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            didx_r      <= 2'd0;
            byte_r      <= 8'h00;
            last_r      <= 1'b0;
            count_r     <= 16'd0;
            crc_r       <= 32'hFFFF_FFFF;
            fcs_r       <= 32'h0000_0000;
            eth_txd     <= 2'b00;
            eth_tx_en   <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
            if (phy_ce) begin
                case (state_r)
                    IDLE: begin
                        if (in_vld) begin
                            state_r   <= PREAMBLE;
                            eth_tx_en <= 1'b1;
                            eth_txd   <= 2'b01;
                            busy      <= 1'b1;
                            crc_r     <= 32'hFFFF_FFFF;
                            cnt_r     <= 8'd1;
                        end
                    end
                    PREAMBLE: begin
                        if (cnt_r != PRE_LAST) begin
                            eth_txd <= 2'b01;
                            cnt_r   <= cnt_r + 8'd1;
                        end else if (in_vld) begin
                            eth_txd <= 2'b11;
                            byte_r  <= in_data;
                            last_r  <= in_last;
                            crc_r   <= crc32_byte(crc_r, in_data);
                            count_r <= 16'd1;
                            didx_r  <= 2'd0;
                            state_r <= DATA;
                        end else begin
                            eth_tx_en   <= 1'b0;
                            eth_txd     <= 2'b00;
                            tx_underrun <= 1'b1;
                            cnt_r       <= 8'd1;
                            state_r     <= IPG;
                        end
                    end
                    DATA, PAD: begin
                        if (didx_r != 2'd3) begin
                            eth_txd <= byte_r[1:0];
                            byte_r  <= {2'b00, byte_r[7:2]};
                            didx_r  <= didx_r + 2'd1;
                        end else if (state_r == DATA && !last_r && !in_vld) begin
                            // Source ran dry mid-frame: abort without FCS.
                            eth_tx_en   <= 1'b0;
                            eth_txd     <= 2'b00;
                            tx_underrun <= 1'b1;
                            cnt_r       <= 8'd1;
                            state_r     <= IPG;
                        end else begin
                            eth_txd <= byte_r[1:0];
                            didx_r  <= 2'd0;
                            if (state_r == DATA && !last_r) begin
                                byte_r  <= in_data;
                                last_r  <= in_last;
                                crc_r   <= crc32_byte(crc_r, in_data);
                                count_r <= count_inc_s;
                            end else if (count_r < MIN_CNT) begin
                                byte_r  <= 8'h00;
                                crc_r   <= crc32_byte(crc_r, 8'h00);
                                count_r <= count_inc_s;
                                state_r <= PAD;
                            end else begin
                                fcs_r   <= ~crc_r;
                                cnt_r   <= 8'd0;
                                state_r <= FCS;
                            end
                        end
                    end
                    FCS: begin
                        if (cnt_r == FCS_END) begin
                            eth_tx_en <= 1'b0;
                            eth_txd   <= 2'b00;
                            tx_done   <= 1'b1;
                            cnt_r     <= 8'd1;
                            state_r   <= IPG;
                        end else begin
                            eth_txd <= fcs_r[1:0];
                            fcs_r   <= {2'b00, fcs_r[31:2]};
                            cnt_r   <= cnt_r + 8'd1;
                        end
                    end
                    IPG: begin
                        // The pulse that dropped tx_en counts as the first gap period.
                        if (cnt_r == IPG_LAST) begin
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        eth_tx_en <= 1'b0;
                        eth_txd   <= 2'b00;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
